// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and the
// arbiter state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches the request vector upward
// (with wrap) starting one past the last-grant pointer and returns the
// first set bit as a one-hot winner. Kept generic for reuse elsewhere.
module rr_pick #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Pick the set request with the smallest distance from last+1
  always_comb begin
    int best_d;
    int best_j;
    int d;
    best_d = N;
    best_j = 0;
    d      = 0;
    grant  = '0;
    for (int j = 0; j < N; j++) begin
      d = (j + 2 * N - 1 - int'(last)) % N;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        best_j = j;
      end
    end
    valid = (best_d < N);
    for (int j = 0; j < N; j++) begin
      grant[j] = valid && (j == best_j);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers. One byte per grant, wait for completion, optional idle gap,
// and a watchdog that abandons a byte if completion never arrives.
// Optional feature macro: UART_ARB_LOCK_EN (requester may hold the grant
// across consecutive bytes for atomic packets).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]             i_req_lock,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_tx_dv,
  output logic [UART_BYTE_W-1:0]         o_tx_byte,
  input  logic                           i_tx_active,
  input  logic                           i_tx_done,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  arb_state_t             state;
  logic [PTR_W-1:0]       last_grant;
  logic [PTR_W-1:0]       cur_idx;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       done_ptr;
  logic [NUM_REQ-1:0]     win_onehot;
  logic                   win_valid;
  logic [UART_BYTE_W-1:0] win_byte;
  logic [WD_W-1:0]        wdog;
  logic [GAP_W-1:0]       gap_cnt;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (i_req),
    .last  (last_grant),
    .grant (win_onehot),
    .valid (win_valid)
  );

  // Encode the winner's index and select its byte
  always_comb begin
    win_idx  = '0;
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_onehot[k]) begin
        win_idx  = PTR_W'(k);
        win_byte = i_req_byte[k*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  // A locked owner parks the pointer just behind itself so it is searched first
  logic lock_r;
  assign done_ptr = lock_r ? ((cur_idx == '0) ? PTR_W'(NUM_REQ - 1) : cur_idx - PTR_W'(1))
                           : cur_idx;
`else
  logic unused_lock;
  assign unused_lock = ^i_req_lock;
  assign done_ptr    = cur_idx;
`endif

  assign o_busy = (state != ST_IDLE);

  // Arbiter FSM: grant, issue, wait for completion or watchdog, optional gap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      last_grant <= PTR_W'(NUM_REQ - 1);
      cur_idx    <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_tx_dv    <= 1'b0;
      o_tx_byte  <= '0;
      o_timeout  <= 1'b0;
      wdog       <= '0;
      gap_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_r     <= 1'b0;
`endif
    end else begin
      o_ack     <= '0;
      o_tx_dv   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid && !i_tx_active) begin
            o_tx_byte <= win_byte;
            o_grant   <= win_onehot;
            o_ack     <= win_onehot;
            cur_idx   <= win_idx;
`ifdef UART_ARB_LOCK_EN
            lock_r    <= |(i_req_lock & win_onehot);
`endif
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_tx_dv <= 1'b1;
          wdog    <= WD_W'(TIMEOUT_CLKS);
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Completion wins over a simultaneous watchdog expiry
          if (i_tx_done) begin
            last_grant <= done_ptr;
            o_grant    <= '0;
            if (GAP_CLKS == 0) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= GAP_W'(GAP_CLKS);
              state   <= ST_GAP;
            end
          end else if (wdog <= WD_W'(1)) begin
            // Abandon the byte; always advancing past the owner also drops any lock
            o_timeout  <= 1'b1;
            o_grant    <= '0;
            last_grant <= cur_idx;
            state      <= ST_IDLE;
          end else begin
            wdog <= wdog - WD_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a main instance with no gap and
// a short watchdog, plus a second instance with a 16-clock gap.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TMO      = 50;
  localparam int GAP      = 16;
  localparam int DONE_DLY = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_lock = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   ack, grant;
  logic           tx_dv, busy, timeout;
  logic [7:0]     tx_byte;
  logic           tx_active = 1'b0;
  logic           tx_done_m = 1'b0;
  logic           man_done = 1'b0;
  logic           tx_done;
  logic           tx_en = 1'b1;
  int             tx_cnt = 0;

  logic [N-1:0]   g_req = '0;
  logic [8*N-1:0] g_byte = 32'h44332211;
  logic [N-1:0]   g_ack, g_grant;
  logic           g_tx_dv, g_busy, g_timeout, g_done = 1'b0;
  logic [7:0]     g_tx_byte;

  assign tx_done = tx_done_m | man_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cyc = 0;

  typedef struct packed {
    logic [7:0]   b;
    logic [N-1:0] g;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  bytes;
    logic [N-1:0] exp_g;
    logic [7:0]   exp_b;
  } vec_t;
  vec_t tbl[8];

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(0), .TIMEOUT_CLKS(TMO)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_byte(req_byte),
    .i_req_lock(req_lock), .o_ack(ack), .o_grant(grant), .o_tx_dv(tx_dv),
    .o_tx_byte(tx_byte), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_busy(busy), .o_timeout(timeout)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) u_gap (
    .i_clk(clk), .i_rst(rst), .i_req(g_req), .i_req_byte(g_byte),
    .i_req_lock(4'b0000), .o_ack(g_ack), .o_grant(g_grant), .o_tx_dv(g_tx_dv),
    .o_tx_byte(g_tx_byte), .i_tx_active(1'b0), .i_tx_done(g_done),
    .o_busy(g_busy), .o_timeout(g_timeout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy from o_tx_dv, completion pulse DONE_DLY+1 clocks later
  always @(posedge clk) begin
    tx_done_m <= 1'b0;
    if (tx_dv) begin
      tx_active <= 1'b1;
      tx_cnt    <= DONE_DLY;
    end else if (tx_active) begin
      if (tx_cnt <= 1) begin
        tx_active <= 1'b0;
        tx_done_m <= tx_en;
      end else begin
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // Scoreboard: every start pulse must match the oldest expected byte/owner
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tx_dv) begin
      dv_cyc = cyc;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: byte %h grant %b, nothing expected", tx_byte, grant);
      end else begin
        e = sb_q.pop_front();
        if (tx_byte !== e.b || grant !== e.g) begin
          errors++;
          $display("FAIL sb_tx: got byte %h grant %b, expected byte %h grant %b",
                   tx_byte, grant, e.b, e.g);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [N-1:0] g);
    exp_t e;
    e.b = b;
    e.g = g;
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input int max, output logic [N-1:0] a);
    a = '0;
    for (int i = 0; i < max && a == '0; i++) begin
      @(negedge clk);
      a = ack;
    end
    if (a == '0) begin
      checks++;
      errors++;
      $display("FAIL wait_ack: no o_ack within %0d cycles", max);
    end
  endtask

  task automatic wait_idle(input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: o_busy still high after %0d cycles", max);
    end
  endtask

  task automatic quiet_window(input string name, input int n);
    int viol;
    viol = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack != '0 || grant != '0 || busy || tx_dv || timeout) viol++;
    end
    chk(name, viol, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a;
    int t0, maxw, cnt0;
    int waits[N];
    logic found;

    tbl[0] = '{4'b0001, 32'h00000055, 4'b0001, 8'h55};
    tbl[1] = '{4'b0110, 32'h23222120, 4'b0010, 8'h21};
    tbl[2] = '{4'b0011, 32'h33323130, 4'b0001, 8'h30};
    tbl[3] = '{4'b1000, 32'h43424140, 4'b1000, 8'h43};
    tbl[4] = '{4'b1010, 32'h53525150, 4'b0010, 8'h51};
    tbl[5] = '{4'b1101, 32'h63626160, 4'b0100, 8'h62};
    tbl[6] = '{4'b1001, 32'h73727170, 4'b1000, 8'h73};
    tbl[7] = '{4'b0110, 32'h83828180, 4'b0010, 8'h81};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single grants, pointer carried from row to row
    for (int v = 0; v < 8; v++) begin
      req      = tbl[v].req;
      req_byte = tbl[v].bytes;
      push(tbl[v].exp_b, tbl[v].exp_g);
      t0 = cyc;
      wait_ack(5, a);
      chk("tbl_ack", a, tbl[v].exp_g);
      chk("tbl_ack_lat", cyc - t0, 1);
      chk("tbl_grant", grant, tbl[v].exp_g);
      req = '0;
      @(negedge clk);
      chk("tbl_ack_pulse", ack, 0);
      chk("tbl_dv", tx_dv, 1);
      wait_idle(40);
      chk("tbl_grant_clr", grant, 0);
    end

    // Reset while waiting for completion; stray completion afterwards
    req      = 4'b0100;
    req_byte = 32'h93929190;
    push(8'h92, 4'b0100);
    wait_ack(5, a);
    chk("mid_ack", a, 4'b0100);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_dv", tx_dv, 0);
    chk("mid_rst_byte", tx_byte, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b0;
    quiet_window("mid_stray_done", 20);

    // All four requesting from a fresh pointer
    req_byte = 32'hA3A2A1A0;
    for (int r = 0; r < 2; r++) begin
      push(8'hA0, 4'b0001);
      push(8'hA1, 4'b0010);
      push(8'hA2, 4'b0100);
      push(8'hA3, 4'b1000);
    end
    for (int k = 0; k < N; k++) waits[k] = 0;
    maxw = 0;
    req  = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_ack(60, a);
      for (int k = 0; k < N; k++) begin
        if (a[k]) waits[k] = 0;
        else begin
          waits[k]++;
          if (waits[k] > maxw) maxw = waits[k];
        end
      end
    end
    req = '0;
    wait_idle(60);
    chk("fair_maxwait", maxw, 3);

    // Watchdog: no completion for the first byte
    tx_en    = 1'b0;
    req_byte = 32'hB3B2B1B0;
    push(8'hB0, 4'b0001);
    push(8'hB1, 4'b0010);
    req = 4'b0011;
    wait_ack(5, a);
    chk("wd_ack0", a, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      found = timeout;
    end
    chk("wd_seen", found, 1);
    chk("wd_delay", cyc - dv_cyc, TMO);
    chk("wd_grant_clr", grant, 0);
    chk("wd_busy", busy, 0);
    tx_en = 1'b1;
    @(negedge clk);
    chk("wd_pulse", timeout, 0);
    chk("wd_next_ack", ack, 4'b0010);
    req = '0;
    wait_idle(60);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    quiet_window("late_done", 8);

    // Locked multi-byte packet from requester 0 with requester 1 waiting
    req_byte = 32'hC3C2C1C0;
`ifdef UART_ARB_LOCK_EN
    push(8'hC0, 4'b0001);
    push(8'hC0, 4'b0001);
    push(8'hC0, 4'b0001);
    push(8'hC1, 4'b0010);
`else
    push(8'hC0, 4'b0001);
    push(8'hC1, 4'b0010);
    push(8'hC0, 4'b0001);
    push(8'hC1, 4'b0010);
`endif
    req_lock = 4'b0001;
    req      = 4'b0011;
    cnt0     = 0;
    for (int n = 0; n < 4; n++) begin
      wait_ack(60, a);
      if (a[0]) begin
        cnt0++;
        if (cnt0 == 3) begin
          req[0]   = 1'b0;
          req_lock = '0;
        end
      end
    end
    req      = '0;
    req_lock = '0;
    wait_idle(60);
`ifdef UART_ARB_LOCK_EN
    chk("lock_cnt0", cnt0, 3);
`else
    chk("lock_cnt0", cnt0, 2);
`endif

    // Gap instance: requests during the gap wait GAP_CLKS extra clocks
    g_req = 4'b0001;
    a     = '0;
    for (int i = 0; i < 5 && a == '0; i++) begin
      @(negedge clk);
      a = g_ack;
    end
    chk("gap_ack0", a, 4'b0001);
    g_req = '0;
    @(negedge clk);
    chk("gap_dv", g_tx_dv, 1);
    chk("gap_byte", g_tx_byte, 8'h11);
    repeat (3) @(negedge clk);
    g_done = 1'b1;
    t0     = cyc;
    @(negedge clk);
    g_done = 1'b0;
    g_req  = 4'b0010;
    chk("gap_busy", g_busy, 1);
    a = '0;
    for (int i = 0; i < 40 && a == '0; i++) begin
      @(negedge clk);
      a = g_ack;
    end
    chk("gap_ack1", a, 4'b0010);
    chk("gap_delay", cyc - t0, GAP + 2);
    g_req = '0;
    repeat (3) @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter between NUM_REQ byte producers, such as a command responder, a status reporter and a debug echo path. It sits between the requesters and the transmitter's i_tx_dv/i_tx_byte/o_tx_done interface. It issues one byte per grant, waits for transmit completion, and enforces an optional inter-byte gap. A watchdog recovers if completion never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
GAP_CLKS, 0, idle clocks inserted after each o_tx_done before the next grant (0 = none).
TIMEOUT_CLKS, 20000, clocks to wait for i_tx_done before abort; must exceed 10*CLKS_PER_BIT.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_req  in  NUM_REQ  per-requester byte-valid; held until acked
i_req_byte  in  8*NUM_REQ  byte k at bits [8k+7:8k]
i_req_lock  in  NUM_REQ  keep grant for the next byte (used only with UART_ARB_LOCK_EN)
o_ack  out  NUM_REQ  one-cycle pulse: requester's byte was accepted
o_grant  out  NUM_REQ  one-hot owner of the byte in flight, else 0
o_tx_dv  out  1  one-cycle start pulse to transmitter
o_tx_byte  out  8  byte to transmitter, stable from o_tx_dv until completion
i_tx_active  in  1  transmitter busy
i_tx_done  in  1  transmitter completion pulse
o_busy  out  1  arbiter not in IDLE
o_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0. State goes to IDLE. Round-robin pointer is set so requester 0 has top priority. Gap and watchdog counters are 0.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: if i_req is nonzero and i_tx_active is 0, select the winner k as the first set bit searching upward (with wrap) from last_grant+1.
  - Register o_tx_byte <= byte k and o_grant <= one-hot k.
  - Pulse o_ack[k] for exactly 1 cycle. The requester may change its byte or drop i_req on the next cycle.
  - Go to ISSUE.
- ISSUE: o_tx_dv = 1 for this single cycle. Load watchdog with TIMEOUT_CLKS. Go to WAIT_DONE.
- Latency: a request seen in IDLE produces o_ack in cycle N+1 (registered) and o_tx_dv in cycle N+2.
- WAIT_DONE: on i_tx_done, set last_grant <= k and clear o_grant.
  - If GAP_CLKS = 0, go to IDLE. Otherwise load the gap counter and go to GAP.
  - Watchdog decrements every cycle. On reaching 0 without done: pulse o_timeout, clear o_grant, advance last_grant, go to IDLE. The byte is not retried.
- GAP: decrement the counter; on reaching 0, go to IDLE. Requests are ignored during GAP.
- i_tx_done outside WAIT_DONE is ignored. i_tx_done in the same cycle as watchdog expiry counts as done, with no timeout pulse.
- Fairness: a requester that stays asserted waits at most NUM_REQ-1 other bytes.
- If a requester drops i_req before ack, it is simply not selected. No partial state is kept.
- Reset mid-transfer: the arbiter returns to IDLE immediately. The byte already in the transmitter completes on the line; the resulting i_tx_done is ignored because the arbiter is in IDLE.
- o_busy = (state != IDLE).

Optional Feature:
Macro UART_ARB_LOCK_EN.
- Defined: if i_req_lock[k] is 1 at ack time, last_grant is not advanced. If the same requester requests again when IDLE is next entered, it wins ahead of all others, giving atomic multi-byte packets. Watchdog abort always releases the lock.
- Undefined: i_req_lock is ignored and the port is left unconnected internally. Arbitration is strictly per-byte round-robin.

Decomposition:
- Package uart_pkg: state encoding constants (ST_IDLE=0, ST_ISSUE=1, ST_WAIT_DONE=2, ST_GAP=3) and UART_BYTE_W=8.
- Sub-module rr_pick: purely combinational. Inputs: request vector and last-grant pointer. Outputs: one-hot winner and valid. Reusable for a future RX dispatcher.

Test Plan:
- Single request: i_req=0001, byte 0x55; model done 10 cycles after dv -> o_ack[0] at N+1, o_tx_dv at N+2, o_tx_byte=0x55, o_grant=0001 until done, o_busy falls after done.
- All requesting: i_req=1111, bytes 0xA0..0xA3 held for 8 bytes -> transmit order A0,A1,A2,A3,A0,A1,A2,A3; no requester waits more than 3 bytes.
- Gap: GAP_CLKS=16 -> exactly 16 cycles between i_tx_done and the next o_ack; requests during GAP are not acked.
- Watchdog: TIMEOUT_CLKS=50, no i_tx_done -> o_timeout pulses once, 50 cycles after o_tx_dv; next requester is granted; a late i_tx_done is ignored.
- Reset mid-transfer: assert i_rst in WAIT_DONE -> all outputs 0 on the next edge; subsequent stray i_tx_done causes no ack or grant.
- Lock (UART_ARB_LOCK_EN): req0 with lock=1 sends 3 bytes while req1 is pending -> bytes 0,0,0 are sent, then req1; without the macro the order is 0,1,0,1.
